// File: rtl/batcharger_ctrl_p.sv
// Battery charge sequencer: walks the charger through trickle, constant-current and
// constant-voltage modes with debounced thresholds, safety timeouts and auto-recharge.
module batcharger_ctrl_p #(
    parameter int W    = 8,
    parameter int TW   = 16,
    parameter int NDEB = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          vtok,
    input  logic [W-1:0]  vbat,
    input  logic [W-1:0]  ibat,
    input  logic [W-1:0]  vpreset,
    input  logic [W-1:0]  vtarget,
    input  logic [W-1:0]  iend,
    input  logic [W-1:0]  vrestart,
    input  logic [TW-1:0] ttc_max,
    input  logic [TW-1:0] tchg_max,
    output logic          tc,
    output logic          cc,
    output logic          cv,
    output logic          vmonen,
    output logic          imonen,
    output logic          done,
    output logic          fault,
    output logic [2:0]    state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_TC    = 3'd2,
        S_CC    = 3'd3,
        S_CV    = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam int DW = (NDEB < 1) ? 1 : $clog2(NDEB + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(NDEB - 1);
    localparam int T_ST = 0;    // state timer (trickle timeout)
    localparam int T_GL = 1;    // global charge timer

    state_t        state_reg, state_next;
    logic [DW-1:0] deb_reg, deb_next;
    logic [TW-1:0] tmr_reg  [2];
    logic [TW-1:0] tmr_next [2];
    logic [TW-1:0] tmr_sat  [2];

    logic cond;
    logic deb_hit;
    logic charging;
    logic ttc_to;
    logic tchg_to;
    logic timeout;
    logic state_chg;

    // Saturating "+1" views: the value each timer reaches if it counts this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tmr_sat
            assign tmr_sat[gi] = (tmr_reg[gi] == {TW{1'b1}}) ? tmr_reg[gi]
                                                             : tmr_reg[gi] + 1'b1;
        end
    endgenerate

    // Threshold the current state is waiting on.
    always_comb begin
        cond = 1'b0;
        case (state_reg)
            S_TC:    cond = (vbat >= vpreset);
            S_CC:    cond = (vbat >= vtarget);
            S_CV:    cond = (ibat <= iend);
            S_DONE:  cond = (vbat < vrestart);
            default: cond = 1'b0;
        endcase
    end

    assign deb_hit  = vtok && cond && (deb_reg == DEB_LAST);
    assign charging = (state_reg == S_TC) || (state_reg == S_CC) || (state_reg == S_CV);
    // Timeouts compare the count including the current cycle, so a limit of N
    // trips on the Nth edge spent in the timed states.
    assign ttc_to   = (state_reg == S_TC) && (ttc_max != '0) && (tmr_sat[T_ST] >= ttc_max);
    assign tchg_to  = charging && (tchg_max != '0) && (tmr_sat[T_GL] >= tchg_max);
    assign timeout  = ttc_to || tchg_to;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (en) state_next = S_START;
            end
            S_START: begin
                if (vtok) begin
                    if (vbat >= vtarget)     state_next = S_DONE;
                    else if (vbat < vpreset) state_next = S_TC;
                    else                     state_next = S_CC;
                end
            end
            S_TC: begin
                if (timeout)      state_next = S_FAULT;
                else if (deb_hit) state_next = S_CC;
            end
            S_CC: begin
                if (timeout)      state_next = S_FAULT;
                else if (deb_hit) state_next = S_CV;
            end
            S_CV: begin
                if (timeout)      state_next = S_FAULT;
                else if (deb_hit) state_next = S_DONE;
            end
            S_DONE: begin
                if (deb_hit) state_next = S_START;
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: state_next = S_IDLE;
        endcase
        if (!en) state_next = S_IDLE;
    end

    assign state_chg = (state_next != state_reg);

    always_comb begin
        deb_next = deb_reg;
        if (state_chg)
            deb_next = '0;
        else if (vtok)
            deb_next = cond ? deb_reg + 1'b1 : '0;
    end

    // Global timer keeps counting across TC->CC->CV and only restarts on START entry.
    always_comb begin
        tmr_next[T_ST] = tmr_reg[T_ST];
        tmr_next[T_GL] = tmr_reg[T_GL];
        if (state_chg)
            tmr_next[T_ST] = '0;
        else if (state_reg == S_TC)
            tmr_next[T_ST] = tmr_sat[T_ST];
        if (state_chg && (state_next == S_START))
            tmr_next[T_GL] = '0;
        else if (charging)
            tmr_next[T_GL] = tmr_sat[T_GL];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            deb_reg       <= '0;
            tmr_reg[T_ST] <= '0;
            tmr_reg[T_GL] <= '0;
        end else begin
            state_reg     <= state_next;
            deb_reg       <= deb_next;
            tmr_reg[T_ST] <= tmr_next[T_ST];
            tmr_reg[T_GL] <= tmr_next[T_GL];
        end
    end

    // Moore decode straight off the state register so reset clears outputs at once.
    assign tc     = (state_reg == S_TC);
    assign cc     = (state_reg == S_CC);
    assign cv     = (state_reg == S_CV);
    assign imonen = (state_reg == S_CV);
    assign vmonen = (state_reg == S_START) || (state_reg == S_TC) || (state_reg == S_CC)
                 || (state_reg == S_CV) || (state_reg == S_DONE);
    assign done   = (state_reg == S_DONE);
    assign fault  = (state_reg == S_FAULT);
    assign state  = state_reg;

endmodule

// File: tb/tb_batcharger_ctrl_p.sv
// Bench for batcharger_ctrl_p: directed charge scenarios with literal expectations,
// then randomized traffic checked every cycle against a cycle-count reference model.
module tb_batcharger_ctrl_p;

    localparam int W    = 8;
    localparam int TW   = 16;
    localparam int NDEB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          vtok = 1'b0;
    logic [W-1:0]  vbat = '0;
    logic [W-1:0]  ibat = '0;
    logic [W-1:0]  vpreset = 8'd153;
    logic [W-1:0]  vtarget = 8'd189;
    logic [W-1:0]  iend = 8'd12;
    logic [W-1:0]  vrestart = 8'd184;
    logic [TW-1:0] ttc_max = '0;
    logic [TW-1:0] tchg_max = '0;
    logic          tc, cc, cv, vmonen, imonen, done, fault;
    logic [2:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    batcharger_ctrl_p #(.W(W), .TW(TW), .NDEB(NDEB)) dut (
        .clk(clk), .rst(rst), .en(en), .vtok(vtok), .vbat(vbat), .ibat(ibat),
        .vpreset(vpreset), .vtarget(vtarget), .iend(iend), .vrestart(vrestart),
        .ttc_max(ttc_max), .tchg_max(tchg_max),
        .tc(tc), .cc(cc), .cv(cv), .vmonen(vmonen), .imonen(imonen),
        .done(done), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {tc,cc,cv,vmonen,imonen,done,fault} for each state code.
    function automatic int exp_outs(input int st);
        case (st)
            1:       return 7'b0001000;
            2:       return 7'b1001000;
            3:       return 7'b0101000;
            4:       return 7'b0011100;
            5:       return 7'b0001010;
            6:       return 7'b0000001;
            default: return 0;
        endcase
    endfunction

    // Reference model: tce = edge number of TC entry, g = charging edges since START entry.
    typedef struct packed {
        int st;
        int streak;
        int tce;
        int g;
    } mstate_t;

    mstate_t m = '0;
    int      m_edge = 0;

    function automatic mstate_t step(input mstate_t cur, input int edge_n);
        mstate_t nx;
        bit meets, thr, to, chg;
        int s2, g2, nst;
        int vb, ib;
        vb = int'(vbat);
        ib = int'(ibat);
        case (cur.st)
            2:       meets = (vb >= int'(vpreset));
            3:       meets = (vb >= int'(vtarget));
            4:       meets = (ib <= int'(iend));
            5:       meets = (vb < int'(vrestart));
            default: meets = 0;
        endcase
        s2  = vtok ? (meets ? cur.streak + 1 : 0) : cur.streak;
        thr = vtok && meets && (s2 >= NDEB);
        chg = (cur.st >= 2) && (cur.st <= 4);
        g2  = chg ? cur.g + 1 : cur.g;
        if (g2 > 65535) g2 = 65535;
        to  = ((cur.st == 2) && (ttc_max != 0) && (edge_n - cur.tce >= int'(ttc_max)))
           || (chg && (tchg_max != 0) && (g2 >= int'(tchg_max)));
        nst = cur.st;
        case (cur.st)
            0: if (en) nst = 1;
            1: if (vtok) nst = (vb >= int'(vtarget)) ? 5 : (vb < int'(vpreset)) ? 2 : 3;
            2: if (to) nst = 6; else if (thr) nst = 3;
            3: if (to) nst = 6; else if (thr) nst = 4;
            4: if (to) nst = 6; else if (thr) nst = 5;
            5: if (thr) nst = 1;
            default: nst = cur.st;
        endcase
        if (!en) nst = 0;
        nx.st = nst;
        if (nst != cur.st) begin
            nx.streak = 0;
            nx.tce    = (nst == 2) ? edge_n : cur.tce;
            nx.g      = (nst == 1) ? 0 : g2;
        end else begin
            nx.streak = s2;
            nx.tce    = cur.tce;
            nx.g      = g2;
        end
        return nx;
    endfunction

    always @(posedge clk) m_edge <= m_edge + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= step(m, m_edge + 1);
    end

    always @(negedge clk) begin
        chk("state", int'(state), m.st);
        chk("outputs", int'({tc, cc, cv, vmonen, imonen, done, fault}), exp_outs(m.st));
        chk("onehot", int'($countones({tc, cc, cv}) <= 1), 1);
    end

    task automatic sample(input int v, input int i);
        @(negedge clk); vtok = 1'b1; vbat = W'(v); ibat = W'(i);
        @(negedge clk); vtok = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic restart();
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        chk("restart_start", int'(state), 1);
    endtask

    task automatic prio_case(input bit drop_en, input int exp_state);
        restart();
        @(negedge clk); vtok = 1'b1; vbat = 8'd160;
        @(negedge clk); vtok = 1'b0;
        chk("prio_cc_entry", int'(state), 3);
        repeat (498) @(negedge clk);
        vtok = 1'b1; vbat = 8'd190;
        @(negedge clk);
        chk("prio_first_sample", int'(state), 3);
        if (drop_en) en = 1'b0;
        @(negedge clk);
        vtok = 1'b0;
        chk(drop_en ? "prio_en_low" : "prio_timeout", int'(state), exp_state);
        en = 1'b1;
    endtask

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_vmonen", int'(vmonen), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_en", int'(state), 0);
        en = 1'b1;
        @(negedge clk);
        chk("full_start", int'(state), 1);

        // Full cycle
        sample(120, 0);  chk("full_tc", int'(state), 2);
        sample(160, 0);  chk("full_tc_deb1", int'(state), 2);
        sample(160, 0);  chk("full_cc", int'(state), 3);
        sample(190, 0);  chk("full_cc_deb1", int'(state), 3);
        sample(190, 50); chk("full_cv", int'(state), 4);
        sample(190, 50); chk("full_cv_hi_i", int'(state), 4);
        sample(190, 10); chk("full_cv_deb1", int'(state), 4);
        sample(190, 10); chk("full_done", int'(state), 5);
        chk("full_done_out", int'(done), 1);

        // Debounce
        restart();
        sample(120, 0); chk("deb_tc", int'(state), 2);
        sample(160, 0); chk("deb_s1", int'(state), 2);
        sample(150, 0); chk("deb_s2", int'(state), 2);
        sample(160, 0); chk("deb_s3", int'(state), 2);
        sample(160, 0); chk("deb_s4", int'(state), 3);

        // Trickle timeout
        ttc_max = 16'd100;
        restart();
        @(negedge clk); vtok = 1'b1; vbat = 8'd120;
        @(negedge clk); vtok = 1'b0;
        chk("ttc_entry", int'(state), 2);
        cnt = 0;
        while (state != 3'd6 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("ttc_cycles", cnt, 100);
        chk("ttc_tc_off", int'(tc), 0);
        repeat (20) @(negedge clk);
        chk("ttc_fault_held", int'(fault), 1);
        en = 1'b0;
        @(negedge clk);
        chk("ttc_en_low", int'(state), 0);
        chk("ttc_fault_clr", int'(fault), 0);
        en = 1'b1;
        @(negedge clk);
        chk("ttc_reenter", int'(state), 1);
        ttc_max = 16'd0;

        // Recharge
        sample(190, 0); chk("rech_done", int'(state), 5);
        sample(186, 0); chk("rech_s1", int'(state), 5);
        sample(183, 0); chk("rech_s2", int'(state), 5);
        sample(183, 0); chk("rech_start", int'(state), 1);
        sample(183, 0); chk("rech_cc", int'(state), 3);

        // Priority: timeout beats threshold, en=0 beats timeout
        tchg_max = 16'd500;
        prio_case(1'b0, 6);
        prio_case(1'b1, 0);
        tchg_max = 16'd0;

        // Asynchronous reset mid-CV
        restart();
        sample(160, 0);
        sample(190, 50);
        sample(190, 50); chk("arst_cv", int'(state), 4);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_cv_off", int'(cv), 0);
        chk("arst_imonen", int'(imonen), 0);
        chk("arst_vmonen", int'(vmonen), 0);
        chk("arst_state", int'(state), 0);
        @(negedge clk); #1 rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk); #1;
            if (c % 400 == 0) begin
                ttc_max  = ($urandom_range(0, 3) == 0) ? 16'd0 : TW'($urandom_range(1, 200));
                tchg_max = ($urandom_range(0, 3) == 0) ? 16'd0 : TW'($urandom_range(1, 900));
            end
            rst  = ($urandom_range(0, 999) == 0);
            en   = ($urandom_range(0, 149) != 0);
            vtok = ($urandom_range(0, 2) == 0);
            vbat = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                               : W'($urandom_range(140, 200));
            ibat = W'($urandom_range(0, 40));
        end
        @(negedge clk); #1;
        rst = 1'b0; vtok = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/batcharger_ctrl_p.md
# batcharger_ctrl_p

Parametrised digital charge controller for the battery charger power block. It samples battery voltage and current codes from the monitor ADC and sequences the charger through trickle-current (TC), constant-current (CC) and constant-voltage (CV) modes, driving the block's `tc`, `cc` and `cv` enables. It adds three features: debounced threshold decisions, trickle and total-charge safety timeouts, and automatic recharge after completion. Code width and timer width are generic.

## Interface
Parameters:
- `W`, 8, width of voltage and current codes. Voltage code = Vbat·(2^W−1)/5 V. Current code full scale = C.
- `TW`, 16, width of the timers and timeout limits.
- `NDEB`, 2, consecutive valid samples that must meet a threshold before a transition. Must be ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  charger enable.
- `vtok`  in  1  one-cycle strobe: `vbat`/`ibat` valid.
- `vbat`  in  W  battery voltage code.
- `ibat`  in  W  battery current code.
- `vpreset`  in  W  TC→CC voltage threshold.
- `vtarget`  in  W  CC→CV voltage threshold.
- `iend`  in  W  CV end-of-charge current.
- `vrestart`  in  W  DONE→recharge voltage threshold.
- `ttc_max`  in  TW  TC timeout in cycles. 0 disables it.
- `tchg_max`  in  TW  total TC+CC+CV timeout in cycles. 0 disables it.
- `tc`, `cc`, `cv`  out  1  charging mode enables. One-hot or all zero.
- `vmonen`  out  1  voltage monitor enable.
- `imonen`  out  1  current monitor enable.
- `done`  out  1  charge complete.
- `fault`  out  1  timeout fault (sticky).
- `state`  out  3  current state code.

## Operation
- States and codes: IDLE=0, START=1, TC=2, CC=3, CV=4, DONE=5, FAULT=6.
- Moore outputs, decoded from the state register:
  - `tc` is 1 in TC only. `cc` is 1 in CC only. `cv` is 1 in CV only.
  - `imonen` is 1 in CV only.
  - `vmonen` is 1 in START, TC, CC, CV and DONE.
  - `done` is 1 in DONE only. `fault` is 1 in FAULT only.
- Transitions:
  - IDLE: if `en`=1 → START.
  - START, on the first `vtok`:
    - `vbat` ≥ `vtarget` → DONE.
    - else `vbat` < `vpreset` → TC.
    - else → CC.
    - No debounce in START.
  - TC:
    - `vbat` ≥ `vpreset` for NDEB consecutive `vtok` samples → CC.
    - state timer ≥ `ttc_max` (with `ttc_max`≠0) → FAULT.
  - CC: `vbat` ≥ `vtarget` for NDEB consecutive samples → CV.
  - CV: `ibat` ≤ `iend` for NDEB consecutive samples → DONE.
  - TC, CC and CV: global timer ≥ `tchg_max` (with `tchg_max`≠0) → FAULT.
  - DONE: `vbat` < `vrestart` for NDEB consecutive samples → START.
  - FAULT: held until `en`=0 or `rst`.
  - Any state except IDLE: `en`=0 → IDLE.
- Debounce counter:
  - Increments on each `vtok` sample that meets the current state's condition.
  - Clears on a `vtok` sample that fails the condition.
  - Clears on every state change.
  - Holds when `vtok`=0.
  - The transition fires on the sample that brings the count to NDEB.
- Timers:
  - The state timer clears on every state change and increments every cycle in TC.
  - The global timer clears on entry to START and increments every cycle in TC, CC and CV.
  - It holds in DONE.
  - Both timers saturate at 2^TW−1; they never wrap.
- All comparisons are unsigned, W bits.

## Timing
- Reset (async assert): state is IDLE and every output is 0. Counters clear. Outputs stay 0 until the first edge after deassertion with `en`=1.
- Latency: a transition is decided at rising edge k. The new state and outputs are visible after edge k, with no further pipeline.
- IDLE→START takes one cycle after `en` rises. START waits indefinitely for `vtok`.
- Simultaneous-event priority, highest first:
  1. `en`=0
  2. timeout
  3. threshold transition
- A threshold met on the same edge that a timeout fires → FAULT.
- The timeout compare is evaluated every cycle, independent of `vtok`.
- `rst` mid-charge: immediate IDLE, all mode enables 0 asynchronously.
- `en` toggled in FAULT: `en`=0 → IDLE; `en`=1 again → START with both timers cleared.

## Test plan
Settings for all scenarios: W=8, NDEB=2, `vpreset`=153, `vtarget`=189, `iend`=12, `vrestart`=184.

- **Full cycle:** `en`=1, `vtok` every 4 cycles. `vbat` steps 120 → 160 → 190, then `ibat` 50 → 10.
  - Required sequence: START → TC → CC (after 2nd sample ≥153) → CV (after 2nd sample ≥189) → DONE (after 2nd `ibat`≤12).
  - `tc`/`cc`/`cv` are one-hot throughout.
- **Debounce:** in TC, samples `vbat`=160, 150, 160, 160.
  - Required: CC only after the 4th sample.
  - The 150 sample clears the count.
- **Trickle timeout:** `ttc_max`=100, `vbat` held at 120.
  - Required: `fault`=1 and state 6 exactly 100 cycles after TC entry.
  - `tc`=0 from then on.
  - `fault` stays 1 until `en`=0.
- **Recharge:** in DONE, `vbat` samples 186, 183, 183.
  - Required: START after the third sample, then CC on the next `vtok` with `vbat`=183.
  - Global timer restarts from 0.
- **Priority:** the CC→CV threshold completes on the same edge the global timer hits `tchg_max`=500.
  - Required: FAULT.
  - Repeat with `en`=0 on that edge. Required: IDLE.
- **Async reset:** assert `rst` mid-CV, between clock edges.
  - Required: `cv`, `imonen` and `vmonen` go to 0 without waiting for a clock edge, and state=0.
